// File: rtl/gsram_pkg.sv
// Shared types and constants for the parametrised grid SRAM and its sequencer.
// Also holds the address-width helper used by both.
package gsram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DUMP  = 2'd2
    } seq_state_e;

    localparam int DEF_ROWS   = 10;
    localparam int DEF_COLS   = 10;
    localparam int DEF_DATA_W = 16;

    // Address width for n entries, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/gsram_seq_ctrl.sv
// Sequencer for whole-array clear and row-by-row dump of the grid SRAM.
// One row counter serves both the clear sweep and the dump beats.
module gsram_seq_ctrl
    import gsram_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int ROW_W = clog2_min1(ROWS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_start,
    input  logic             dump_start,
    input  logic             dump_ready,
    output logic             busy,
    output logic             clr_en,
    output logic [ROW_W-1:0] clr_row,
    output logic             dump_valid,
    output logic [ROW_W-1:0] dump_row,
    output logic             dump_done
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    seq_state_e       state, state_nxt;
    logic [ROW_W-1:0] cnt;
    logic             last;
    logic             done_q;

    assign last = (cnt == LAST_ROW);

    // Reset lands in CLEAR so the array is zeroed before first use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_CLEAR;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == ST_DUMP) && dump_ready && last;
            case (state)
                ST_CLEAR: cnt <= last ? '0 : cnt + 1'b1;
                ST_DUMP:  if (dump_ready) cnt <= last ? '0 : cnt + 1'b1;
                default:  cnt <= '0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (clr_start)       state_nxt = ST_CLEAR;
                else if (dump_start) state_nxt = ST_DUMP;
            end
            ST_CLEAR: if (last)               state_nxt = ST_IDLE;
            ST_DUMP:  if (dump_ready && last) state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        clr_en     = (state == ST_CLEAR);
        clr_row    = cnt;
        dump_valid = (state == ST_DUMP);
        dump_row   = (state == ST_DUMP) ? cnt : '0;
        dump_done  = done_q;
    end

endmodule

// File: rtl/gsram_2d_param.sv
// Row/column addressed grid SRAM with write-source mux, accumulate-on-write,
// registered reads and a sequenced clear / row dump port.
module gsram_2d_param
    import gsram_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROW_W  = clog2_min1(ROWS),
    parameter int COL_W  = clog2_min1(COLS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic                   re,
    input  logic [ROW_W-1:0]       row,
    input  logic [COL_W-1:0]       col,
    input  logic                   inmuxsel,
    input  logic [DATA_W-1:0]      m2result,
    input  logic [DATA_W-1:0]      lutdata,
    input  logic                   acc_en,
    output logic [DATA_W-1:0]      rdata,
    output logic                   rvalid,
    output logic                   addr_err,
    input  logic                   clr_start,
    input  logic                   dump_start,
    input  logic                   dump_ready,
    output logic                   dump_valid,
    output logic [ROW_W-1:0]       dump_row,
    output logic [COLS*DATA_W-1:0] dump_data,
    output logic                   dump_done,
    output logic                   busy
);

    localparam logic [ROW_W:0] ROWS_L = (ROW_W + 1)'(ROWS);
    localparam logic [COL_W:0] COLS_L = (COL_W + 1)'(COLS);

    logic [DATA_W-1:0] mem [ROWS][COLS];
    logic [DATA_W-1:0] wdata;
    logic              in_range;
    logic              acc_req;
    logic              wr_ok;
    logic              rd_req;
    logic              clr_en;
    logic [ROW_W-1:0]  clr_row;

    // Accumulate wraps modulo 2^DATA_W; no saturation on this path.
    function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    gsram_seq_ctrl #(
        .ROWS  (ROWS),
        .ROW_W (ROW_W)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_start  (clr_start),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .busy       (busy),
        .clr_en     (clr_en),
        .clr_row    (clr_row),
        .dump_valid (dump_valid),
        .dump_row   (dump_row),
        .dump_done  (dump_done)
    );

    assign wdata    = inmuxsel ? lutdata : m2result;
    assign in_range = ({1'b0, row} < ROWS_L) && ({1'b0, col} < COLS_L);
    assign acc_req  = !busy && (we || re);
    assign wr_ok    = !busy && we && in_range;
    assign rd_req   = !busy && re && !we;

    always_ff @(posedge clk) begin
        if (clr_en) begin
            for (int c = 0; c < COLS; c++) mem[clr_row][c] <= '0;
        end else if (wr_ok) begin
            mem[row][col] <= acc_en ? wrap_add(mem[row][col], wdata) : wdata;
        end
    end

    // Read stage: out-of-range reads still answer, with zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata    <= '0;
            rvalid   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rvalid   <= rd_req;
            addr_err <= acc_req && !in_range;
            if (rd_req) rdata <= in_range ? mem[row][col] : '0;
        end
    end

    always_comb begin
        dump_data = '0;
        if (dump_valid) begin
            for (int c = 0; c < COLS; c++)
                dump_data[(COLS-1-c)*DATA_W +: DATA_W] = mem[dump_row][c];
        end
    end

endmodule

// File: tb/tb_gsram_2d_param.sv
// Bench for gsram_2d_param: directed vector table, randomized accesses against
// an array model, and hand sequences for dump, contention and reset mid-dump.
module tb_gsram_2d_param;

    localparam int ROWS = 10;
    localparam int COLS = 10;
    localparam int DW   = 16;
    localparam int RW   = 4;
    localparam int CW   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 we, re, inmuxsel, acc_en;
    logic [RW-1:0]        row;
    logic [CW-1:0]        col;
    logic [DW-1:0]        m2result, lutdata;
    logic [DW-1:0]        rdata;
    logic                 rvalid, addr_err;
    logic                 clr_start, dump_start, dump_ready;
    logic                 dump_valid, dump_done, busy;
    logic [RW-1:0]        dump_row;
    logic [COLS*DW-1:0]   dump_data;

    gsram_2d_param #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ROW_W(RW), .COL_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .re(re), .row(row), .col(col),
        .inmuxsel(inmuxsel), .m2result(m2result), .lutdata(lutdata),
        .acc_en(acc_en), .rdata(rdata), .rvalid(rvalid), .addr_err(addr_err),
        .clr_start(clr_start), .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dump_valid), .dump_row(dump_row), .dump_data(dump_data),
        .dump_done(dump_done), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] model [ROWS][COLS];
    logic [DW-1:0] exp_rdata;
    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic          w, r;
        logic [RW-1:0] ro;
        logic [CW-1:0] co;
        logic          s;
        logic [DW-1:0] m, l;
        logic          a;
        logic          ev;
        logic [DW-1:0] ed;
        logic          ee;
        string         name;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic w, input logic r, input int ro, input int co,
                                input logic s, input int m, input int l, input logic a,
                                input logic ev, input int ed, input logic ee, input string nm);
        vec_t v;
        v.w = w; v.r = r; v.ro = RW'(ro); v.co = CW'(co); v.s = s;
        v.m = DW'(m); v.l = DW'(l); v.a = a; v.ev = ev; v.ed = DW'(ed); v.ee = ee;
        v.name = nm;
        return v;
    endfunction

    function automatic logic [159:0] row_of(input int r);
        logic [159:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) v[(COLS-1-c)*DW +: DW] = model[r][c];
        return v;
    endfunction

    // Reference: what one idle-state access does to the array and the read port.
    task automatic model_op(input logic w, input logic r, input logic [RW-1:0] ro,
                            input logic [CW-1:0] co, input logic s, input logic [DW-1:0] m,
                            input logic [DW-1:0] l, input logic a,
                            output logic ev, output logic ee);
        logic [DW-1:0] wd;
        bit ok;
        wd = s ? l : m;
        ok = (int'(ro) < ROWS) && (int'(co) < COLS);
        ee = (w || r) && !ok;
        ev = r && !w;
        if (w && ok) model[ro][co] = a ? DW'(model[ro][co] + wd) : wd;
        if (r && !w) exp_rdata = ok ? model[ro][co] : '0;
    endtask

    task automatic drive_op(input logic w, input logic r, input logic [RW-1:0] ro,
                            input logic [CW-1:0] co, input logic s, input logic [DW-1:0] m,
                            input logic [DW-1:0] l, input logic a);
        we = w; re = r; row = ro; col = co; inmuxsel = s; m2result = m; lutdata = l; acc_en = a;
        tick();
        we = 0; re = 0; acc_en = 0;
    endtask

    task automatic access(input logic w, input logic r, input int ro, input int co,
                          input logic s, input int m, input int l, input logic a, input string nm);
        logic ev, ee;
        model_op(w, r, RW'(ro), CW'(co), s, DW'(m), DW'(l), a, ev, ee);
        drive_op(w, r, RW'(ro), CW'(co), s, DW'(m), DW'(l), a);
        chk({nm, "_rvalid"}, rvalid, ev);
        chk({nm, "_rdata"}, rdata, exp_rdata);
        chk({nm, "_addr_err"}, addr_err, ee);
    endtask

    task automatic clear_model();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) model[r][c] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, beat, k;
        bit seen;
        logic ev, ee;

        rst_n = 0; we = 0; re = 0; row = 0; col = 0; inmuxsel = 0; acc_en = 0;
        m2result = 0; lutdata = 0; clr_start = 0; dump_start = 0; dump_ready = 0;
        exp_rdata = '0;
        clear_model();

        tick(); tick();
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_dump_row", dump_row, 0);
        chk("rst_dump_data", dump_data, 0);
        chk("rst_dump_done", dump_done, 0);
        chk("rst_busy", busy, 1);

        rst_n = 1;
        n = 0;
        while (busy && n < 50) begin tick(); n++; end
        chk("reset_clear_cycles", n, 10);

        vt.push_back(mk(0,1, 3,7, 0,0,0,0,      1,16'h0000,0, "rd_after_reset"));
        vt.push_back(mk(0,0, 0,0, 0,0,0,0,      0,16'h0000,0, "idle_pulse_end"));
        vt.push_back(mk(1,0, 2,5, 0,16'h1234,16'h9999,0, 0,16'h0000,0, "wr_m2"));
        vt.push_back(mk(1,0, 2,6, 1,16'h1111,16'hBEEF,0, 0,16'h0000,0, "wr_lut"));
        vt.push_back(mk(0,1, 2,5, 0,0,0,0,      1,16'h1234,0, "rd_m2"));
        vt.push_back(mk(0,1, 2,6, 0,0,0,0,      1,16'hBEEF,0, "rd_lut"));
        vt.push_back(mk(1,0, 0,0, 0,16'hFFF0,0,0, 0,16'hBEEF,0, "wr_fff0"));
        vt.push_back(mk(1,0, 0,0, 0,16'h0020,0,1, 0,16'hBEEF,0, "acc_wrap"));
        vt.push_back(mk(0,1, 0,0, 0,0,0,0,      1,16'h0010,0, "rd_wrap"));
        vt.push_back(mk(1,0, 10,0, 1,0,16'h5555,0, 0,16'h0010,1, "wr_oob"));
        vt.push_back(mk(0,1, 0,12, 0,0,0,0,     1,16'h0000,1, "rd_oob"));
        vt.push_back(mk(0,1, 0,0, 0,0,0,0,      1,16'h0010,0, "rd_after_oob"));
        vt.push_back(mk(1,1, 2,5, 0,16'h7777,0,0, 0,16'h0010,0, "we_re_both"));
        vt.push_back(mk(0,1, 2,5, 0,0,0,0,      1,16'h7777,0, "rd_both"));
        vt.push_back(mk(1,0, 2,6, 1,0,16'h0001,1, 0,16'h7777,0, "acc_lut"));
        vt.push_back(mk(0,1, 2,6, 0,0,0,0,      1,16'hBEF0,0, "rd_acc_lut"));
        vt.push_back(mk(0,1, 15,15, 0,0,0,0,    1,16'h0000,1, "rd_oob_both"));

        foreach (vt[i]) begin
            model_op(vt[i].w, vt[i].r, vt[i].ro, vt[i].co, vt[i].s, vt[i].m, vt[i].l, vt[i].a, ev, ee);
            drive_op(vt[i].w, vt[i].r, vt[i].ro, vt[i].co, vt[i].s, vt[i].m, vt[i].l, vt[i].a);
            chk({vt[i].name, "_rvalid"}, rvalid, vt[i].ev);
            chk({vt[i].name, "_rdata"}, rdata, vt[i].ed);
            chk({vt[i].name, "_addr_err"}, addr_err, vt[i].ee);
        end

        for (int i = 0; i < 400; i++) begin
            access(1'($urandom), 1'($urandom), int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                   1'($urandom), int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                   1'($urandom), "rand");
        end

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                model_op(1, 0, RW'(r), CW'(c), 0, DW'(r*16 + c), 0, 0, ev, ee);
                drive_op(1, 0, RW'(r), CW'(c), 0, DW'(r*16 + c), 0, 0);
            end

        dump_start = 1;
        tick();
        dump_start = 0;
        chk("dump_first_beat_valid", dump_valid, 1);
        beat = 0; k = 0;
        while (beat < ROWS && k < 200) begin
            chk("dump_valid", dump_valid, 1);
            chk("dump_row", dump_row, beat);
            chk("dump_data", dump_data, row_of(beat));
            chk("dump_no_done", dump_done, 0);
            chk("dump_busy_no_rvalid", rvalid, 0);
            dump_ready = k[0];
            we = 1; re = 1; row = 1; col = 1; inmuxsel = 0; m2result = 16'hDEAD;
            if (dump_ready) beat++;
            tick();
            k++;
        end
        we = 0; re = 0; dump_ready = 0;
        chk("dump_beats", beat, ROWS);
        chk("dump_end_valid", dump_valid, 0);
        chk("dump_done_pulse", dump_done, 1);
        chk("dump_end_busy", busy, 0);
        tick();
        chk("dump_done_single", dump_done, 0);
        access(0, 1, 1, 1, 0, 0, 0, 0, "busy_write_ignored");

        clr_start = 1; dump_start = 1;
        tick();
        clr_start = 0; dump_start = 0;
        n = 0; seen = 0;
        while (busy && n < 50) begin
            if (dump_valid) seen = 1;
            tick();
            n++;
        end
        chk("contention_clear_cycles", n, 10);
        chk("contention_no_dump", seen, 0);
        clear_model();
        access(0, 1, 2, 5, 0, 0, 0, 0, "rd_after_clear");
        access(0, 1, 9, 9, 0, 0, 0, 0, "rd_after_clear_last");

        dump_start = 1;
        tick();
        dump_start = 0;
        tick(); tick();
        chk("middump_valid", dump_valid, 1);
        chk("middump_row", dump_row, 0);
        #2 rst_n = 0;
        #1;
        chk("middump_rst_valid", dump_valid, 0);
        chk("middump_rst_busy", busy, 1);
        chk("middump_rst_done", dump_done, 0);
        chk("middump_rst_data", dump_data, 0);
        tick();
        rst_n = 1;
        dump_ready = 1;
        n = 0; seen = 0;
        while (busy && n < 50) begin
            if (dump_done || dump_valid) seen = 1;
            tick();
            n++;
        end
        if (dump_done) seen = 1;
        chk("middump_clear_cycles", n, 10);
        chk("middump_no_done", seen, 0);
        dump_ready = 0;
        exp_rdata = '0;
        access(0, 1, 2, 5, 0, 0, 0, 0, "rd_after_middump");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gsram_2d_param.md
Name: gsram_2d_param

Overview:
- Parametrised successor to the fixed 10x10x16 grid SRAM in the systolic/LUT datapath.
- Row/column-addressed 2D storage with a write-source mux (multiplier result or LUT data) and optional accumulate-on-write.
- Single-cycle registered reads.
- Sequencer FSM for whole-array clear and row-by-row result dump with valid/ready handshake; replaces the always-on full-array output buses.

Parameters:
ROWS, 10, number of rows (>=1)
COLS, 10, number of columns (>=1)
DATA_W, 16, element width in bits
ROW_W, clog2(ROWS) (min 1), row address width
COL_W, clog2(COLS) (min 1), column address width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
we  in  1  write enable
re  in  1  read enable
row  in  ROW_W  row address
col  in  COL_W  column address
inmuxsel  in  1  write source: 0 = m2result, 1 = lutdata
m2result  in  DATA_W  multiplier result write data
lutdata  in  DATA_W  LUT write data
acc_en  in  1  1 = mem[row][col] += wdata; 0 = overwrite
rdata  out  DATA_W  registered read data
rvalid  out  1  one-cycle pulse, rdata valid
addr_err  out  1  one-cycle pulse, out-of-range access
clr_start  in  1  start array clear
dump_start  in  1  start row dump
dump_ready  in  1  consumer accepts dump beat
dump_valid  out  1  dump beat valid
dump_row  out  ROW_W  row index of current beat
dump_data  out  COLS*DATA_W  row contents, col 0 in MSBs, col COLS-1 in LSBs
dump_done  out  1  one-cycle pulse after last beat accepted
busy  out  1  FSM not IDLE

Behaviour:
- Reset (async assert, sync release): rdata=0, rvalid=0, addr_err=0, dump_valid=0, dump_row=0, dump_data=0, dump_done=0. FSM enters CLEAR (busy=1). Array contents are not reset directly; they are zeroed by CLEAR.
- FSM states:
  - IDLE: clr_start -> CLEAR; else dump_start -> DUMP. If both are asserted, clear wins.
  - CLEAR: zeroes one full row per cycle, rows 0..ROWS-1; ROWS cycles, then IDLE.
  - DUMP: presents rows 0..ROWS-1 in order.
    - dump_valid=1, dump_data = row dump_row, sampled from the array in the same cycle.
    - Advances only on dump_valid & dump_ready; dump_valid/dump_row/dump_data hold stable while ready=0.
    - After the last beat is accepted: dump_valid=0, dump_done pulses 1 cycle, -> IDLE.
    - First beat is visible the cycle after dump_start.
- While busy: we, re, clr_start and dump_start are ignored (no write, no rvalid).
- IDLE access:
  - wdata = inmuxsel ? lutdata : m2result.
  - we=1: write at the edge; with acc_en, store (mem + wdata) mod 2^DATA_W (wraps, no saturation).
  - we=1 and re=1 together: write only, no rvalid.
  - re=1, we=0: rdata = mem[row][col] the next cycle, rvalid pulses 1 cycle; rdata holds its value otherwise.
  - Read of an address written in the previous cycle returns the new value.
- Out-of-range (row>=ROWS or col>=COLS):
  - write is dropped;
  - read returns rdata=0 with rvalid=1;
  - addr_err pulses one cycle in both cases.
- Reset mid-CLEAR or mid-DUMP: outputs go to reset values immediately, FSM restarts CLEAR. Any partial dump is abandoned without dump_done.

Decomposition:
- Package gsram_pkg: FSM state enum (IDLE, CLEAR, DUMP), default ROWS/COLS/DATA_W constants, clog2 helper function.
- Sub-module gsram_seq_ctrl: FSM plus row counter. Produces busy, clear-row strobe/index, dump_valid/dump_row/dump_done.
- Array, write mux and accumulate adder live in the top module.

Test Plan:
- Reset then wait: busy=1 for exactly 10 cycles. Then re at (3,7) -> rdata=0x0000, rvalid pulses once.
- Overwrite then read: inmuxsel=0, m2result=0x1234 to (2,5); inmuxsel=1, lutdata=0xBEEF to (2,6). Reads -> 0x1234 and 0xBEEF, each with 1-cycle latency.
- Accumulate with wrap: write 0xFFF0 to (0,0), then acc_en=1 with 0x0020. Read -> 0x0010.
- Out of range: we at (10,0) -> addr_err pulses, array unchanged. re at (0,12) -> rdata=0, rvalid=1, addr_err=1.
- Dump with backpressure: fill mem[r][c]=r*16+c, dump_start. Toggle dump_ready every other cycle -> 10 beats in order, each dump_data row with col 0 in MSBs, held stable while ready=0. dump_done pulses once after beat 9.
- Contention: clr_start and dump_start asserted together -> CLEAR runs, no dump_valid. Then assert rst_n=0 mid-dump -> dump_valid drops immediately, CLEAR restarts, no dump_done.
